hello_cpu_0_debug_jtag_host: RTL and testbench

//  Host-side virtual-JTAG sequencer for the CPU debug slave: drives tck/tdi, ir_in and the

---
 rtl/hello_cpu_0_debug_jtag_host_if.sv | 36 +++
 rtl/hello_cpu_0_debug_jtag_host.sv | 160 ++++++++++++++++
 tb/tb_hello_cpu_0_debug_jtag_host.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/hello_cpu_0_debug_jtag_host_if.sv
// Command/response and virtual-JTAG pin bundle between the debug host sequencer and its user.
// The slave modport is the sequencer side; the master modport is the initiator/slave-model side.
interface hello_cpu_0_debug_jtag_host_if #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [DR_WIDTH-1:0] cmd_dr;
  logic                rsp_valid;
  logic [DR_WIDTH-1:0] rsp_dr;
  logic [IR_WIDTH-1:0] rsp_ir_out;
  logic                vji_tck;
  logic                vji_tdi;
  logic                vji_tdo;
  logic [IR_WIDTH-1:0] vji_ir_in;
  logic [IR_WIDTH-1:0] vji_ir_out;
  logic                vji_rti;
  logic                vji_uir;
  logic                vji_cdr;
  logic                vji_sdr;
  logic                vji_udr;

  modport slave (
    input  cmd_valid, cmd_ir, cmd_dr, vji_tdo, vji_ir_out,
    output cmd_ready, rsp_valid, rsp_dr, rsp_ir_out,
    output vji_tck, vji_tdi, vji_ir_in, vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr
  );

  modport master (
    output cmd_valid, cmd_ir, cmd_dr, vji_tdo, vji_ir_out,
    input  cmd_ready, rsp_valid, rsp_dr, rsp_ir_out,
    input  vji_tck, vji_tdi, vji_ir_in, vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr
  );
endinterface

// File: rtl/hello_cpu_0_debug_jtag_host.sv
// Virtual-JTAG host: each accepted command runs IR-update, DR capture/shift/update, then a 1-cycle response.
// Latency (DR_WIDTH+3)*2*TCK_DIV+1 clks from accept to rsp_valid; commands are refused (not queued) while busy.
module hello_cpu_0_debug_jtag_host #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 4
) (
  input  logic clk,
  input  logic reset,
  hello_cpu_0_debug_jtag_host_if.slave host
);

  if (TCK_DIV < 1) begin : g_bad_tck_div
    $error("TCK_DIV must be at least 1");
  end

  localparam int PER  = 2 * TCK_DIV;
  localparam int DIVW = (PER > 2) ? $clog2(PER) : 1;
  localparam int BITW = (DR_WIDTH > 2) ? $clog2(DR_WIDTH) : 1;

  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(PER - 1);
  localparam logic [DIVW-1:0] DIV_RISE = DIVW'(TCK_DIV - 1);
  localparam logic [DIVW-1:0] DIV_HIGH = DIVW'(TCK_DIV);
  localparam logic [BITW-1:0] BIT_LAST = BITW'(DR_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UIR,
    S_CDR,
    S_SDR,
    S_UDR,
    S_RSP
  } state_t;

  state_t              state_q, state_d;
  logic [DIVW-1:0]     div_q, div_d;
  logic [BITW-1:0]     bit_q, bit_d;
  logic [DR_WIDTH-1:0] shift_q, shift_d;
  logic [DR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [IR_WIDTH-1:0] irout_q, irout_d;
  logic                tdi_q, tdi_d;
  logic                live_q;

  logic in_txn;
  logic period_end;
  logic tck_rise;
  logic ready;
  logic accept;

  assign in_txn     = (state_q == S_UIR) || (state_q == S_CDR) ||
                      (state_q == S_SDR) || (state_q == S_UDR);
  assign period_end = in_txn && (div_q == DIV_LAST);
  // div_q == DIV_RISE is the last low cycle, so the next edge is the one where tck rises
  assign tck_rise   = in_txn && (div_q == DIV_RISE);
  // live_q keeps cmd_ready low while reset is held and for the release cycle
  assign ready      = live_q && (state_q == S_IDLE);
  assign accept     = host.cmd_valid && ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_UIR;
      S_UIR:   if (period_end) state_d = S_CDR;
      S_CDR:   if (period_end) state_d = S_SDR;
      S_SDR:   if (period_end && (bit_q == BIT_LAST)) state_d = S_UDR;
      S_UDR:   if (period_end) state_d = S_RSP;
      S_RSP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    host.vji_tck   = in_txn && (div_q >= DIV_HIGH);
    host.vji_rti   = (state_q == S_IDLE);
    host.vji_uir   = (state_q == S_UIR);
    host.vji_cdr   = (state_q == S_CDR);
    host.vji_sdr   = (state_q == S_SDR);
    host.vji_udr   = (state_q == S_UDR);
    host.rsp_valid = (state_q == S_RSP);
    host.cmd_ready = ready;
  end

  always_comb begin
    div_d    = '0;
    bit_d    = bit_q;
    shift_d  = shift_q;
    ir_d     = ir_q;
    irout_d  = irout_q;
    tdi_d    = tdi_q;
    rsp_dr_d = rsp_dr_q;

    if (in_txn && !period_end) begin
      div_d = div_q + 1'b1;
    end

    if (accept) begin
      ir_d    = host.cmd_ir;
      shift_d = host.cmd_dr;
      bit_d   = '0;
    end

    if (tck_rise && (state_q == S_UIR)) begin
      irout_d = host.vji_ir_out;
    end

    if (tck_rise && (state_q == S_SDR)) begin
      shift_d = {host.vji_tdo, shift_q[DR_WIDTH-1:1]};
    end

    if (period_end && (state_q == S_SDR)) begin
      bit_d = bit_q + 1'b1;
    end

    // tdi only moves at a period boundary, so it is stable across the tck rise
    if (period_end) begin
      tdi_d = (state_d == S_SDR) ? shift_d[0] : 1'b0;
    end

    if (period_end && (state_q == S_UDR)) begin
      rsp_dr_d = shift_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      ir_q     <= '0;
      irout_q  <= '0;
      tdi_q    <= 1'b0;
      rsp_dr_q <= '0;
      live_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      ir_q     <= ir_d;
      irout_q  <= irout_d;
      tdi_q    <= tdi_d;
      rsp_dr_q <= rsp_dr_d;
      live_q   <= 1'b1;
    end
  end

  assign host.vji_tdi    = tdi_q;
  assign host.vji_ir_in  = ir_q;
  assign host.rsp_dr     = rsp_dr_q;
  assign host.rsp_ir_out = irout_q;

endmodule

// File: tb/tb_hello_cpu_0_debug_jtag_host.sv
// Bench for the virtual-JTAG host: table vectors plus random commands against a cycle-level waveform model.
// A second instance built with TCK_DIV=1 checks the fast-tck latency and loopback integrity.
module tb_hello_cpu_0_debug_jtag_host;

  localparam int DRW  = 38;
  localparam int IRW  = 2;
  localparam int D0   = 4;
  localparam int D1   = 1;
  localparam int LAT0 = (DRW + 3) * 2 * D0 + 1;
  localparam int LAT1 = (DRW + 3) * 2 * D1 + 1;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;

  always #5 clk = ~clk;

  hello_cpu_0_debug_jtag_host_if #(.DR_WIDTH(DRW), .IR_WIDTH(IRW)) if0 ();
  hello_cpu_0_debug_jtag_host_if #(.DR_WIDTH(DRW), .IR_WIDTH(IRW)) if1 ();

  hello_cpu_0_debug_jtag_host #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_DIV(D0)) dut0 (
    .clk   (clk),
    .reset (rst0),
    .host  (if0)
  );

  hello_cpu_0_debug_jtag_host #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_DIV(D1)) dut1 (
    .clk   (clk),
    .reset (rst1),
    .host  (if1)
  );

  assign if1.vji_tdo    = if1.vji_tdi;
  assign if1.vji_ir_out = 2'b11;

  typedef struct {
    logic [IRW-1:0] ir;
    logic [DRW-1:0] dr;
    bit             lb;
    logic [DRW-1:0] bits;
    logic [IRW-1:0] irout;
    bit             hold;
    logic [DRW-1:0] exp_dr;
    logic [IRW-1:0] exp_ir;
  } vec_t;

  vec_t           tbl [5];
  int             n_cmp = 0;
  int             n_bad = 0;
  logic [DRW-1:0] last_rsp;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 20) $display("FAIL %s: got %h, wanted %h", nm, act, exp);
    end
  endtask

  function automatic logic [10:0] pins0();
    return {if0.vji_tck, if0.vji_rti, if0.vji_uir, if0.vji_cdr, if0.vji_sdr, if0.vji_udr,
            if0.vji_tdi, if0.vji_ir_in, if0.cmd_ready, if0.rsp_valid};
  endfunction

  // Expected pins t cycles after the accepting edge, from the period schedule:
  // period 0 UIR, 1 CDR, 2..DRW+1 SDR (bit p-2 on tdi), DRW+2 UDR, then one RSP cycle.
  function automatic logic [10:0] model(input int t, input int lat, input int d,
                                        input logic [IRW-1:0] ir, input logic [DRW-1:0] dr);
    int   p;
    int   ph;
    logic tck, uir, cdr, sdr, udr, tdi, rv;
    p   = (t - 1) / (2 * d);
    ph  = (t - 1) % (2 * d);
    rv  = (t == lat);
    tck = 1'b0; uir = 1'b0; cdr = 1'b0; sdr = 1'b0; udr = 1'b0; tdi = 1'b0;
    if (!rv) begin
      tck = (ph >= d);
      uir = (p == 0);
      cdr = (p == 1);
      sdr = (p >= 2) && (p < DRW + 2);
      udr = (p == DRW + 2);
      if (sdr) tdi = dr[p-2];
    end
    return {tck, 1'b0, uir, cdr, sdr, udr, tdi, ir, 1'b0, rv};
  endfunction

  task automatic chk_reset(input string nm);
    chk({nm, " pins"}, 64'(pins0()), 64'(11'b010_0000_0000));
    chk({nm, " rsp"}, 64'({if0.rsp_ir_out, if0.rsp_dr}), 64'd0);
  endtask

  task automatic run_txn(input string nm, input logic [IRW-1:0] ir, input logic [DRW-1:0] dr,
                         input bit lb, input logic [DRW-1:0] bits, input logic [IRW-1:0] irout,
                         input bit hold, input int abort_t,
                         output logic [DRW-1:0] got_dr, output logic [IRW-1:0] got_ir);
    int p;
    got_dr = '0;
    got_ir = '0;
    @(negedge clk);
    chk({nm, " ready"}, 64'(if0.cmd_ready), 64'd1);
    if0.cmd_valid  = 1'b1;
    if0.cmd_ir     = ir;
    if0.cmd_dr     = dr;
    if0.vji_ir_out = irout;
    if0.vji_tdo    = 1'($urandom);
    for (int t = 1; t <= LAT0; t++) begin
      @(negedge clk);
      if (t == abort_t) begin
        rst0 = 1'b1;
        #1;
        chk_reset({nm, " abort"});
        if0.cmd_valid = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk_reset({nm, " held"});
        end
        rst0     = 1'b0;
        last_rsp = '0;
        return;
      end
      chk({nm, " cyc"}, 64'(pins0()), 64'(model(t, LAT0, D0, ir, dr)));
      if (t == LAT0) begin
        got_dr = if0.rsp_dr;
        got_ir = if0.rsp_ir_out;
      end else if (t == LAT0 - 1) begin
        chk({nm, " rsp hold"}, 64'(if0.rsp_dr), 64'(last_rsp));
      end
      // Busy-time command inputs are garbage; the DUT must neither sample nor queue them
      if0.cmd_valid = hold ? 1'b1 : 1'($urandom);
      if0.cmd_ir    = 2'($urandom);
      if0.cmd_dr    = 38'({$urandom, $urandom});
      p = (t - 1) / (2 * D0);
      if ((p >= 2) && (p < DRW + 2)) if0.vji_tdo = lb ? if0.vji_tdi : bits[p-2];
      else                           if0.vji_tdo = 1'($urandom);
    end
    if (!hold) if0.cmd_valid = 1'b0;
    last_rsp = got_dr;
  endtask

  initial begin
    logic [DRW-1:0] gd;
    logic [IRW-1:0] gi;
    logic [DRW-1:0] rdr;
    logic [DRW-1:0] rbits;
    logic [IRW-1:0] rir;
    logic [IRW-1:0] rio;
    bit             rlb;
    int             cyc;
    int             rises;
    logic           prev_tck;
    bit             done;

    tbl[0] = '{2'b01, 38'h2A_5555_AAAA, 1'b1, 38'h0,           2'b01, 1'b0, 38'h2A_5555_AAAA, 2'b01};
    tbl[1] = '{2'b10, 38'h15_0F0F_F0F0, 1'b0, 38'h3F_FFFF_FFFF, 2'b10, 1'b0, 38'h3F_FFFF_FFFF, 2'b10};
    tbl[2] = '{2'b11, 38'h3F_FFFF_FFFF, 1'b0, 38'h0,           2'b11, 1'b1, 38'h0,           2'b11};
    tbl[3] = '{2'b00, 38'h0,           1'b0, 38'h2A_AAAA_5555, 2'b00, 1'b1, 38'h2A_AAAA_5555, 2'b00};
    tbl[4] = '{2'b01, 38'h00_0000_0001, 1'b1, 38'h0,           2'b01, 1'b0, 38'h00_0000_0001, 2'b01};

    rst0 = 1'b1;
    rst1 = 1'b1;
    if0.cmd_valid = 1'b0; if0.cmd_ir = '0; if0.cmd_dr = '0; if0.vji_tdo = 1'b0; if0.vji_ir_out = '0;
    if1.cmd_valid = 1'b0; if1.cmd_ir = '0; if1.cmd_dr = '0;
    last_rsp = '0;

    repeat (3) begin
      @(negedge clk);
      chk_reset("reset");
    end
    rst0 = 1'b0;
    rst1 = 1'b0;
    #1;
    chk("ready before edge", 64'(if0.cmd_ready), 64'd0);

    for (int i = 0; i < 5; i++) begin
      run_txn($sformatf("vec%0d", i), tbl[i].ir, tbl[i].dr, tbl[i].lb, tbl[i].bits,
              tbl[i].irout, tbl[i].hold, 0, gd, gi);
      chk($sformatf("vec%0d rsp_dr", i), 64'(gd), 64'(tbl[i].exp_dr));
      chk($sformatf("vec%0d rsp_ir_out", i), 64'(gi), 64'(tbl[i].exp_ir));
    end

    for (int i = 0; i < 6; i++) begin
      rdr   = 38'({$urandom, $urandom});
      rbits = 38'({$urandom, $urandom});
      rir   = 2'($urandom);
      rio   = 2'($urandom);
      rlb   = 1'($urandom);
      run_txn($sformatf("rnd%0d", i), rir, rdr, rlb, rbits, rio, 1'($urandom), 0, gd, gi);
      chk($sformatf("rnd%0d rsp_dr", i), 64'(gd), 64'(rlb ? rdr : rbits));
      chk($sformatf("rnd%0d rsp_ir_out", i), 64'(gi), 64'(rio));
    end

    // Reset lands in SDR bit 20: period 22, third cycle of it
    run_txn("abort", 2'b10, 38'h12_3456_789A, 1'b1, 38'h0, 2'b01, 1'b0, 22 * 2 * D0 + 3, gd, gi);
    run_txn("post", 2'b01, 38'h2A_5555_AAAA, 1'b1, 38'h0, 2'b10, 1'b0, 0, gd, gi);
    chk("post rsp_dr", 64'(gd), 64'(38'h2A_5555_AAAA));
    chk("post rsp_ir_out", 64'(gi), 64'(2'b10));

    @(negedge clk);
    chk("div1 ready", 64'(if1.cmd_ready), 64'd1);
    if1.cmd_valid = 1'b1;
    if1.cmd_ir    = 2'b10;
    if1.cmd_dr    = 38'h15_3C3C_C3C3;
    cyc = 0; rises = 0; prev_tck = 1'b0; done = 1'b0;
    while (!done && (cyc < 200)) begin
      @(negedge clk);
      cyc++;
      if1.cmd_valid = 1'b0;
      if (if1.vji_tck && !prev_tck) rises++;
      prev_tck = if1.vji_tck;
      if (if1.rsp_valid) done = 1'b1;
    end
    chk("div1 latency", 64'(cyc), 64'(LAT1));
    chk("div1 tck rises", 64'(rises), 64'(DRW + 3));
    chk("div1 rsp_dr", 64'(if1.rsp_dr), 64'(38'h15_3C3C_C3C3));
    chk("div1 rsp_ir_out", 64'(if1.rsp_ir_out), 64'(2'b11));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
